ex_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline, sitting directly downstream of the ID/EX register and feeding the MEM stage. It forwards operands from EX/MEM and MEM/WB and runs the ALU. It contains an iterative 32-cycle multiplier with HI/LO registers and owns the EX/MEM pipeline register. While a multiply is in progress it asserts a stall that freezes every upstream stage.

---
 rtl/ex_stage_if.sv | 30 +++
 rtl/ex_stage.sv | 132 +++++++++++++
 tb/tb_ex_stage.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs, MEM/WB forwarding source and EX/MEM outputs of the execute stage
interface ex_stage_if;
  logic        reg_dst_idex, reg_write_idex, alu_src_idex;
  logic        mem_read_idex, mem_write_idex, mem_to_reg_idex;
  logic [2:0]  alu_op_idex;
  logic [5:0]  func_idex;
  logic [31:0] signextend_idex, rs_data_idex, rt_data_idex;
  logic [4:0]  rs_idex, rt_idex, rd_idex;
  logic        reg_write_memwb;
  logic [4:0]  rd_memwb;
  logic [31:0] wb_data_memwb;
  logic        ex_stall;
  logic        reg_write_exmem, mem_read_exmem, mem_write_exmem, mem_to_reg_exmem;
  logic [31:0] alu_result_exmem, store_data_exmem;
  logic [4:0]  rd_exmem;
  modport master (
    output reg_dst_idex, reg_write_idex, alu_src_idex, mem_read_idex, mem_write_idex,
           mem_to_reg_idex, alu_op_idex, func_idex, signextend_idex, rs_data_idex,
           rt_data_idex, rs_idex, rt_idex, rd_idex, reg_write_memwb, rd_memwb, wb_data_memwb,
    input  ex_stall, reg_write_exmem, mem_read_exmem, mem_write_exmem, mem_to_reg_exmem,
           alu_result_exmem, store_data_exmem, rd_exmem
  );
  modport slave (
    input  reg_dst_idex, reg_write_idex, alu_src_idex, mem_read_idex, mem_write_idex,
           mem_to_reg_idex, alu_op_idex, func_idex, signextend_idex, rs_data_idex,
           rt_data_idex, rs_idex, rt_idex, rd_idex, reg_write_memwb, rd_memwb, wb_data_memwb,
    output ex_stall, reg_write_exmem, mem_read_exmem, mem_write_exmem, mem_to_reg_exmem,
           alu_result_exmem, store_data_exmem, rd_exmem
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with forwarding, ALU, 32-cycle shift-add multiplier, HI/LO and EX/MEM register
module ex_stage (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [64:0] prod_q, prod_d;
  logic [31:0] mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
  logic        neg_q, neg_d;
  logic        reg_write_q, reg_write_d, mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;
  logic [31:0] result_q, result_d, store_q, store_d;
  logic [4:0]  rd_q, rd_d;
  logic        ex_ok, fwd_ex_a, fwd_ex_b, fwd_wb_a, fwd_wb_b, is_mult, sgn, stall;
  logic [31:0] a, b, op_b, r_res, alu_res;
  logic [32:0] upper;
  logic [4:0]  shamt;
  // a load in EX/MEM has no value yet; the hazard unit stalls that case
  assign ex_ok    = reg_write_q && !mem_read_q && rd_q != 5'd0;
  assign fwd_ex_a = ex_ok && rd_q == bus.rs_idex;
  assign fwd_ex_b = ex_ok && rd_q == bus.rt_idex;
  assign fwd_wb_a = bus.reg_write_memwb && bus.rd_memwb != 5'd0 && bus.rd_memwb == bus.rs_idex;
  assign fwd_wb_b = bus.reg_write_memwb && bus.rd_memwb != 5'd0 && bus.rd_memwb == bus.rt_idex;
  assign a     = fwd_ex_a ? result_q : fwd_wb_a ? bus.wb_data_memwb : bus.rs_data_idex;
  assign b     = fwd_ex_b ? result_q : fwd_wb_b ? bus.wb_data_memwb : bus.rt_data_idex;
  assign op_b  = bus.alu_src_idex ? bus.signextend_idex : b;
  assign shamt = bus.signextend_idex[10:6];
  assign is_mult = bus.alu_op_idex == 3'b010 && bus.func_idex[5:1] == 5'b01100;
  assign sgn     = !bus.func_idex[0];
  assign stall   = is_mult && state_q != DONE && !rst;
  assign upper   = prod_q[64:32] + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
  always_comb begin
    r_res = bus.func_idex == 6'b100000 ? a + op_b :
            bus.func_idex == 6'b100010 ? a - op_b :
            bus.func_idex == 6'b100100 ? a & op_b :
            bus.func_idex == 6'b100101 ? a | op_b :
            bus.func_idex == 6'b100110 ? a ^ op_b :
            bus.func_idex == 6'b100111 ? ~(a | op_b) :
            bus.func_idex == 6'b101010 ? {31'd0, $signed(a) < $signed(op_b)} :
            bus.func_idex == 6'b000000 ? b << shamt :
            bus.func_idex == 6'b000010 ? b >> shamt :
            bus.func_idex == 6'b010000 ? hi_q :
            bus.func_idex == 6'b010010 ? lo_q : 32'd0;
    alu_res = bus.alu_op_idex == 3'b000 ? a + op_b :
              bus.alu_op_idex == 3'b001 ? a - op_b :
              bus.alu_op_idex == 3'b010 ? r_res :
              bus.alu_op_idex == 3'b011 ? a & op_b :
              bus.alu_op_idex == 3'b100 ? a | op_b :
              bus.alu_op_idex == 3'b101 ? {31'd0, $signed(a) < $signed(op_b)} : 32'd0;
  end
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: if (is_mult) begin
        mcand_d = sgn && a[31] ? -a : a;
        prod_d  = {33'd0, sgn && b[31] ? -b : b};
        neg_d   = sgn && (a[31] ^ b[31]);
        count_d = 5'd0;
        state_d = BUSY;
      end
      BUSY: begin
        prod_d  = {1'b0, upper, prod_q[31:1]};
        count_d = count_q + 5'd1;
        state_d = count_q == 5'd31 ? DONE : BUSY;
      end
      DONE: begin
        {hi_d, lo_d} = neg_q ? -prod_q[63:0] : prod_q[63:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    reg_write_d  = stall || state_q == DONE ? 1'b0 : bus.reg_write_idex;
    mem_read_d   = stall ? 1'b0 : bus.mem_read_idex;
    mem_write_d  = stall ? 1'b0 : bus.mem_write_idex;
    mem_to_reg_d = stall ? 1'b0 : bus.mem_to_reg_idex;
    result_d     = stall || state_q == DONE ? 32'd0 : alu_res;
    store_d      = stall ? 32'd0 : b;
    rd_d         = stall ? 5'd0 : bus.reg_dst_idex ? bus.rd_idex : bus.rt_idex;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      prod_q <= '0;
      mcand_q <= '0;
      neg_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      reg_write_q <= 1'b0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_to_reg_q <= 1'b0;
      result_q <= '0;
      store_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      prod_q <= prod_d;
      mcand_q <= mcand_d;
      neg_q <= neg_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      reg_write_q <= reg_write_d;
      mem_read_q <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      result_q <= result_d;
      store_q <= store_d;
      rd_q <= rd_d;
    end
  end
  assign bus.ex_stall         = stall;
  assign bus.reg_write_exmem  = reg_write_q;
  assign bus.mem_read_exmem   = mem_read_q;
  assign bus.mem_write_exmem  = mem_write_q;
  assign bus.mem_to_reg_exmem = mem_to_reg_q;
  assign bus.alu_result_exmem = result_q;
  assign bus.store_data_exmem = store_q;
  assign bus.rd_exmem         = rd_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed checks of forwarding, ALU, multiplier timing, HI/LO and reset
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int n;
  int bub_bad;
  ex_stage_if bus();
  ex_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_op(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                        input logic [31:0] rtd);
    bus.alu_op_idex = op;
    bus.func_idex = fn;
    bus.rs_idex = rs;
    bus.rt_idex = rt;
    bus.rd_idex = rd;
    bus.rs_data_idex = rsd;
    bus.rt_data_idex = rtd;
    bus.reg_dst_idex = 1'b1;
    bus.reg_write_idex = 1'b1;
    bus.alu_src_idex = 1'b0;
    bus.mem_read_idex = 1'b0;
    bus.mem_write_idex = 1'b0;
    bus.mem_to_reg_idex = 1'b0;
    bus.signextend_idex = 32'd0;
    bus.reg_write_memwb = 1'b0;
    bus.rd_memwb = 5'd0;
    bus.wb_data_memwb = 32'd0;
  endtask
  task automatic run_mult(input string tag);
    #1;
    chk({tag, "_entry_stall"}, {31'd0, bus.ex_stall}, 32'd1);
    n = 0;
    bub_bad = 0;
    while (bus.ex_stall && n < 40) begin
      n++;
      step();
      if (bus.reg_write_exmem || bus.mem_read_exmem || bus.mem_write_exmem ||
          bus.mem_to_reg_exmem || bus.alu_result_exmem != 0 || bus.store_data_exmem != 0 ||
          bus.rd_exmem != 0)
        bub_bad++;
    end
    chk({tag, "_stall_cycles"}, n, 32'd33);
    chk({tag, "_bubbles"}, bub_bad, 32'd0);
    step();
    chk({tag, "_done_regwrite"}, {31'd0, bus.reg_write_exmem}, 32'd0);
    chk({tag, "_done_result"}, bus.alu_result_exmem, 32'd0);
  endtask
  initial begin
    set_op(3'b000, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    bus.reg_write_idex = 1'b0;
    #2;
    chk("rst_stall", {31'd0, bus.ex_stall}, 32'd0);
    chk("rst_result", bus.alu_result_exmem, 32'd0);
    chk("rst_ctrl", {bus.reg_write_exmem, bus.mem_read_exmem, bus.mem_write_exmem,
                     bus.mem_to_reg_exmem, bus.rd_exmem}, 32'd0);
    step();
    rst = 1'b0;
    set_op(3'b010, 6'b100000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    step();
    chk("add_5_7", bus.alu_result_exmem, 32'd12);
    set_op(3'b010, 6'b100000, 5'd3, 5'd3, 5'd4, 32'd0, 32'd0);
    step();
    chk("fwd_exmem", bus.alu_result_exmem, 32'd24);
    chk("fwd_rd", {27'd0, bus.rd_exmem}, 32'd4);
    set_op(3'b010, 6'b100000, 5'd1, 5'd2, 5'd3, 32'd4, 32'd5);
    step();
    set_op(3'b010, 6'b100010, 5'd3, 5'd0, 5'd5, 32'h55, 32'd0);
    bus.reg_write_memwb = 1'b1;
    bus.rd_memwb = 5'd3;
    bus.wb_data_memwb = 32'd4;
    step();
    chk("fwd_priority", bus.alu_result_exmem, 32'd9);
    set_op(3'b010, 6'b100000, 5'd1, 5'd2, 5'd0, 32'd9, 32'd0);
    step();
    set_op(3'b010, 6'b100010, 5'd0, 5'd0, 5'd5, 32'd2, 32'd0);
    bus.reg_write_memwb = 1'b1;
    bus.wb_data_memwb = 32'd4;
    step();
    chk("fwd_zero_idx", bus.alu_result_exmem, 32'd2);
    set_op(3'b010, 6'b100000, 5'd3, 5'd0, 5'd6, 32'd0, 32'd0);
    bus.reg_write_memwb = 1'b1;
    bus.rd_memwb = 5'd3;
    bus.wb_data_memwb = 32'd4;
    step();
    chk("fwd_memwb", bus.alu_result_exmem, 32'd4);
    set_op(3'b000, 6'd0, 5'd1, 5'd7, 5'd0, 32'h100, 32'd0);
    bus.alu_src_idex = 1'b1;
    bus.reg_dst_idex = 1'b0;
    bus.reg_write_idex = 1'b0;
    bus.mem_write_idex = 1'b1;
    bus.signextend_idex = 32'd8;
    bus.reg_write_memwb = 1'b1;
    bus.rd_memwb = 5'd7;
    bus.wb_data_memwb = 32'hDEADBEEF;
    step();
    chk("sw_store", bus.store_data_exmem, 32'hDEADBEEF);
    chk("sw_addr", bus.alu_result_exmem, 32'h108);
    chk("sw_memwrite", {31'd0, bus.mem_write_exmem}, 32'd1);
    set_op(3'b000, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    bus.reg_write_idex = 1'b0;
    step();
    set_op(3'b010, 6'b011000, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFD, 32'd5);
    bus.reg_write_idex = 1'b0;
    run_mult("mult");
    set_op(3'b010, 6'b010000, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0);
    step();
    chk("mfhi_mult", bus.alu_result_exmem, 32'hFFFFFFFF);
    set_op(3'b010, 6'b010010, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0);
    step();
    chk("mflo_mult", bus.alu_result_exmem, 32'hFFFFFFF1);
    set_op(3'b010, 6'b011001, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 32'd2);
    bus.reg_write_idex = 1'b0;
    run_mult("multu");
    set_op(3'b010, 6'b010000, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0);
    step();
    chk("mfhi_multu", bus.alu_result_exmem, 32'd1);
    set_op(3'b010, 6'b010010, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0);
    step();
    chk("mflo_multu", bus.alu_result_exmem, 32'hFFFFFFFE);
    set_op(3'b010, 6'b011000, 5'd1, 5'd2, 5'd0, 32'd7, 32'd9);
    bus.reg_write_idex = 1'b0;
    for (int i = 0; i < 11; i++) step();
    chk("busy_stall", {31'd0, bus.ex_stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", {31'd0, bus.ex_stall}, 32'd0);
    chk("rst_mid_out", {bus.reg_write_exmem, bus.mem_write_exmem, bus.rd_exmem} | bus.alu_result_exmem, 32'd0);
    set_op(3'b010, 6'b010000, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0);
    #2;
    rst = 1'b0;
    step();
    chk("mfhi_after_rst", bus.alu_result_exmem, 32'd0);
    chk("mfhi_after_rst_rd", {27'd0, bus.rd_exmem}, 32'd8);
    set_op(3'b010, 6'b000000, 5'd0, 5'd2, 5'd9, 32'd0, 32'h0000000F);
    bus.signextend_idex = 32'h00000100;
    step();
    chk("sll_4", bus.alu_result_exmem, 32'h000000F0);
    set_op(3'b010, 6'b101010, 5'd1, 5'd2, 5'd10, 32'hFFFFFFFF, 32'd1);
    step();
    chk("slt_neg", bus.alu_result_exmem, 32'd1);
    set_op(3'b010, 6'b111111, 5'd1, 5'd2, 5'd11, 32'd3, 32'd4);
    step();
    chk("undef_func", bus.alu_result_exmem, 32'd0);
    set_op(3'b100, 6'd0, 5'd1, 5'd2, 5'd12, 32'hF0, 32'h0F);
    step();
    chk("or_op", bus.alu_result_exmem, 32'hFF);
    set_op(3'b110, 6'd0, 5'd1, 5'd2, 5'd12, 32'hF0, 32'h0F);
    step();
    chk("op_110", bus.alu_result_exmem, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
